matriz_determinante_n: RTL and testbench

- Parametrised sequential determinant engine for square signed-integer matrices of runtime size 1..MAX_N.
- Successor to the fixed 5x5 Laplace unit in the ULA. Uses fraction-free Bareiss elimination with row-swap pivoting, one element update per cycle, so hardware cost grows with element count rather than with cofactor count.
- Adds a start/busy/done handshake, an async reset, size checking, and a saturation flag.

---
 rtl/matriz_determinante_n_if.sv | 26 ++
 rtl/matriz_determinante_n.sv | 174 +++++++++++++++++
 tb/tb_matriz_determinante_n.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/matriz_determinante_n_if.sv
// Request/result bundle for the sequential determinant engine.
// The requester drives inicio/tamanho/matriz; the engine returns status and result.
interface matriz_determinante_n_if #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int OUT_W  = 8
);
  logic                            inicio;
  logic [7:0]                      tamanho;
  logic [MAX_N*MAX_N*DATA_W-1:0]   matriz;
  logic                            ocupado;
  logic                            pronto;
  logic signed [OUT_W-1:0]         resultado;
  logic                            saturado;
  logic                            erro_tamanho;

  modport master (
    output inicio, tamanho, matriz,
    input  ocupado, pronto, resultado, saturado, erro_tamanho
  );

  modport slave (
    input  inicio, tamanho, matriz,
    output ocupado, pronto, resultado, saturado, erro_tamanho
  );
endinterface

// File: rtl/matriz_determinante_n.sv
// Sequential determinant engine: fraction-free Bareiss elimination with row-swap
// pivoting, one matrix element updated per clock.
module matriz_determinante_n #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  matriz_determinante_n_if.slave bus
);
  localparam int IW = $clog2(MAX_N);
  localparam logic [IW-1:0] ONE = IW'(1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(OUT_W-1)));

  typedef enum logic [2:0] {OCIOSO, ERRO, CARGA, PIVO, TROCA, ELIM, FIM} state_t;

  state_t state_reg, state_next;

  logic signed [ACC_W-1:0] a_reg [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] elem_ext [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] prev_reg;
  logic [IW-1:0]           nm1_reg, k_reg, r_reg, i_reg, j_reg;
  logic                    neg_reg, zero_reg;
  logic                    pronto_reg, saturado_reg, erro_reg;
  logic signed [OUT_W-1:0] resultado_reg;

  for (genvar gi = 0; gi < MAX_N; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_N; gj++) begin : g_col
      assign elem_ext[gi][gj] = ACC_W'($signed(bus.matriz[(MAX_N*gi+gj)*DATA_W +: DATA_W]));
    end
  end

  logic                      tam_ok, piv_nz, last_elem;
  logic [IW-1:0]             k_inc;
  logic signed [2*ACC_W-1:0] prod_a, prod_b, diff, quot;
  logic signed [ACC_W-1:0]   diag_last, det;
  logic                      sat_hi, sat_lo;
  logic signed [OUT_W-1:0]   det_sat;

  assign tam_ok    = (bus.tamanho != 8'd0) && (bus.tamanho <= 8'(MAX_N));
  assign piv_nz    = (a_reg[r_reg][k_reg] != '0);
  assign last_elem = (i_reg == nm1_reg) && (j_reg == nm1_reg);
  assign k_inc     = k_reg + ONE;

  // Double-width product keeps the Bareiss numerator exact before the exact divide.
  assign prod_a = (2*ACC_W)'(a_reg[i_reg][j_reg]) * (2*ACC_W)'(a_reg[k_reg][k_reg]);
  assign prod_b = (2*ACC_W)'(a_reg[i_reg][k_reg]) * (2*ACC_W)'(a_reg[k_reg][j_reg]);
  assign diff   = prod_a - prod_b;
  assign quot   = diff / (2*ACC_W)'(prev_reg);

  assign diag_last = a_reg[nm1_reg][nm1_reg];
  assign det       = zero_reg ? '0 : (neg_reg ? -diag_last : diag_last);
  assign sat_hi    = det > MAXV;
  assign sat_lo    = det < MINV;
  assign det_sat   = sat_hi ? MAXV[OUT_W-1:0] : (sat_lo ? MINV[OUT_W-1:0] : det[OUT_W-1:0]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO: if (bus.inicio) state_next = tam_ok ? CARGA : ERRO;
      ERRO:   state_next = OCIOSO;
      CARGA:  state_next = (nm1_reg == '0) ? FIM : PIVO;
      PIVO: begin
        if (piv_nz)                 state_next = (r_reg == k_reg) ? ELIM : TROCA;
        else if (r_reg == nm1_reg)  state_next = FIM;
      end
      TROCA:  state_next = ELIM;
      ELIM:   if (last_elem) state_next = (k_inc == nm1_reg) ? FIM : PIVO;
      FIM:    state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= OCIOSO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_N; i++)
        for (int j = 0; j < MAX_N; j++)
          a_reg[i][j] <= '0;
      prev_reg      <= '0;
      nm1_reg       <= '0;
      k_reg         <= '0;
      r_reg         <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      neg_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      pronto_reg    <= 1'b0;
      saturado_reg  <= 1'b0;
      erro_reg      <= 1'b0;
      resultado_reg <= '0;
    end else begin
      pronto_reg <= 1'b0;
      case (state_reg)
        OCIOSO: begin
          // The operands are captured at the accept edge so the requester may change them afterwards.
          if (bus.inicio && tam_ok) begin
            for (int i = 0; i < MAX_N; i++)
              for (int j = 0; j < MAX_N; j++)
                a_reg[i][j] <= elem_ext[i][j];
            nm1_reg <= IW'(bus.tamanho - 8'd1);
          end
        end
        ERRO: begin
          pronto_reg    <= 1'b1;
          erro_reg      <= 1'b1;
          saturado_reg  <= 1'b0;
          resultado_reg <= '0;
        end
        CARGA: begin
          k_reg    <= '0;
          r_reg    <= '0;
          prev_reg <= ACC_W'(1);
          neg_reg  <= 1'b0;
          zero_reg <= 1'b0;
        end
        PIVO: begin
          if (piv_nz) begin
            i_reg <= k_inc;
            j_reg <= k_inc;
          end else if (r_reg == nm1_reg) begin
            zero_reg <= 1'b1;
          end else begin
            r_reg <= r_reg + ONE;
          end
        end
        TROCA: begin
          for (int c = 0; c < MAX_N; c++) begin
            a_reg[k_reg][c] <= a_reg[r_reg][c];
            a_reg[r_reg][c] <= a_reg[k_reg][c];
          end
          neg_reg <= ~neg_reg;
        end
        ELIM: begin
          a_reg[i_reg][j_reg] <= quot[ACC_W-1:0];
          if (j_reg == nm1_reg) begin
            j_reg <= k_inc;
            i_reg <= i_reg + ONE;
          end else begin
            j_reg <= j_reg + ONE;
          end
          if (last_elem) begin
            prev_reg <= a_reg[k_reg][k_reg];
            k_reg    <= k_inc;
            r_reg    <= k_inc;
          end
        end
        FIM: begin
          pronto_reg    <= 1'b1;
          erro_reg      <= 1'b0;
          saturado_reg  <= sat_hi | sat_lo;
          resultado_reg <= det_sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.ocupado      = (state_reg != OCIOSO);
  assign bus.pronto       = pronto_reg;
  assign bus.resultado    = resultado_reg;
  assign bus.saturado     = saturado_reg;
  assign bus.erro_tamanho = erro_reg;
endmodule

// File: tb/tb_matriz_determinante_n.sv
// Directed and randomized checks of the determinant engine against a Leibniz-formula model.
module tb_matriz_determinante_n;
  localparam int DATA_W = 8;
  localparam int MAX_N  = 5;
  localparam int ACC_W  = 48;
  localparam int OUT_W  = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  matriz_determinante_n_if #(.DATA_W(DATA_W), .MAX_N(MAX_N), .OUT_W(OUT_W)) bus ();

  matriz_determinante_n #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int mat [MAX_N][MAX_N];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [MAX_N*MAX_N*DATA_W-1:0] pack_mat();
    logic [MAX_N*MAX_N*DATA_W-1:0] v = '0;
    for (int i = 0; i < MAX_N; i++)
      for (int j = 0; j < MAX_N; j++)
        v[(MAX_N*i+j)*DATA_W +: DATA_W] = DATA_W'(mat[i][j]);
    return v;
  endfunction

  // Leibniz sum over all permutations, enumerated as base-n digit tuples.
  function automatic longint ref_det(input int n);
    longint sum = 0;
    int total = 1;
    for (int i = 0; i < n; i++) total *= n;
    for (int t = 0; t < total; t++) begin
      int p [MAX_N];
      bit used [MAX_N];
      bit ok = 1'b1;
      int d = t;
      int inv = 0;
      longint prod = 1;
      for (int i = 0; i < MAX_N; i++) used[i] = 1'b0;
      for (int i = 0; i < n; i++) begin
        p[i] = d % n;
        d = d / n;
        if (used[p[i]]) ok = 1'b0;
        used[p[i]] = 1'b1;
      end
      if (ok) begin
        for (int i = 0; i < n; i++)
          for (int j = i + 1; j < n; j++)
            if (p[i] > p[j]) inv++;
        for (int i = 0; i < n; i++) prod *= longint'(mat[i][p[i]]);
        sum += (inv % 2 == 1) ? -prod : prod;
      end
    end
    return sum;
  endfunction

  task automatic clear_mat();
    for (int i = 0; i < MAX_N; i++)
      for (int j = 0; j < MAX_N; j++)
        mat[i][j] = 0;
  endtask

  task automatic garble_inputs();
    for (int b = 0; b < MAX_N*MAX_N; b++)
      bus.matriz[b*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    bus.tamanho = 8'($urandom_range(0, 255));
  endtask

  task automatic start(input int n);
    @(negedge clock);
    bus.inicio  = 1'b1;
    bus.tamanho = 8'(n);
    bus.matriz  = pack_mat();
    @(posedge clock);
    #1;
    bus.inicio = 1'b0;
    garble_inputs();
  endtask

  task automatic run(input string tag, input int n, input int exp_lat, input bit poke);
    longint d = 0;
    logic signed [63:0] exp_res;
    bit exp_sat, exp_err;
    bit ocup_ok = 1'b1;
    int cyc = 0;
    exp_err = (n < 1) || (n > MAX_N);
    if (exp_err) begin
      exp_res = 0;
      exp_sat = 1'b0;
    end else begin
      d = ref_det(n);
      exp_sat = (d > 127) || (d < -128);
      exp_res = (d > 127) ? 127 : ((d < -128) ? -128 : d);
    end
    start(n);
    if (bus.ocupado !== 1'b1) ocup_ok = 1'b0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      if (poke && cyc == 5) begin
        bus.inicio  = 1'b1;
        bus.tamanho = 8'd2;
      end else if (poke && cyc == 6) begin
        bus.inicio = 1'b0;
      end
      if (bus.pronto !== 1'b1 && bus.ocupado !== 1'b1) ocup_ok = 1'b0;
    end while (bus.pronto !== 1'b1 && cyc < 400);
    check($sformatf("%s.pronto_seen", tag), 64'(bus.pronto), 1);
    if (exp_lat >= 0) check($sformatf("%s.latency", tag), cyc, exp_lat);
    check($sformatf("%s.resultado", tag), bus.resultado, exp_res);
    check($sformatf("%s.saturado", tag), 64'(bus.saturado), 64'(exp_sat));
    check($sformatf("%s.erro_tamanho", tag), 64'(bus.erro_tamanho), 64'(exp_err));
    check($sformatf("%s.ocupado", tag), 64'(ocup_ok), 1);
    $display("txn %s n=%0d det=%0d latency=%0d resultado=%0d saturado=%0b erro=%0b",
             tag, n, d, cyc, bus.resultado, bus.saturado, bus.erro_tamanho);
  endtask

  initial begin
    bus.inicio  = 1'b0;
    bus.tamanho = '0;
    bus.matriz  = '0;
    clear_mat();
    repeat (3) @(posedge clock);
    #1;
    check("reset.ocupado", 64'(bus.ocupado), 0);
    check("reset.pronto", 64'(bus.pronto), 0);
    check("reset.resultado", bus.resultado, 0);
    check("reset.saturado", 64'(bus.saturado), 0);
    check("reset.erro", 64'(bus.erro_tamanho), 0);
    @(negedge clock);
    reset_n = 1'b1;

    clear_mat();
    for (int i = 0; i < 5; i++) mat[i][i] = 1;
    run("ident5", 5, 36, 1'b0);

    clear_mat();
    mat[0][0] = 3; mat[0][1] = 4; mat[1][0] = 2; mat[1][1] = 5;
    run("m2_basic", 2, 4, 1'b0);

    clear_mat();
    mat[0][1] = 1; mat[1][0] = 1;
    run("m2_swap", 2, 6, 1'b0);

    clear_mat();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        mat[i][j] = 3*i + j + 1;
    run("m3_singular", 3, -1, 1'b0);

    clear_mat();
    mat[0][0] = 2;  mat[0][1] = -1;
    mat[1][0] = -1; mat[1][1] = 2;  mat[1][2] = -1;
    mat[2][1] = -1; mat[2][2] = 2;
    run("m3_tridiag", 3, 9, 1'b0);

    clear_mat();
    for (int i = 0; i < 5; i++) mat[i][i] = 10;
    run("diag_pos", 5, 36, 1'b0);
    mat[0][0] = -10;
    run("diag_neg", 5, 36, 1'b0);

    // Abort mid-elimination: outputs clear at once and no pronto follows.
    clear_mat();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        mat[i][j] = int'($urandom_range(0, 6)) - 3;
    start(5);
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort.ocupado", 64'(bus.ocupado), 0);
    check("abort.pronto", 64'(bus.pronto), 0);
    check("abort.resultado", bus.resultado, 0);
    check("abort.saturado", 64'(bus.saturado), 0);
    check("abort.erro", 64'(bus.erro_tamanho), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    begin
      bit pronto_seen = 1'b0;
      repeat (50) begin
        @(posedge clock);
        #1;
        if (bus.pronto === 1'b1) pronto_seen = 1'b1;
      end
      check("abort.no_pronto", 64'(pronto_seen), 0);
    end
    $display("txn abort_mid_elim reset applied, outputs cleared");

    clear_mat();
    for (int i = 0; i < 5; i++) mat[i][i] = 1;
    mat[0][0] = 3; mat[1][1] = -2;
    run("after_abort", 5, 36, 1'b0);

    run("size0", 0, 1, 1'b0);
    run("size6", 6, 1, 1'b0);
    clear_mat();
    mat[0][0] = 3; mat[0][1] = 4; mat[1][0] = 2; mat[1][1] = 5;
    run("err_clear", 2, 4, 1'b0);

    clear_mat();
    for (int i = 0; i < 5; i++) mat[i][i] = 1;
    mat[2][2] = 5; mat[4][4] = -3; mat[0][3] = 7;
    run("busy_poke", 5, 36, 1'b1);

    for (int t = 0; t < 30; t++) begin
      int n = int'($urandom_range(1, MAX_N));
      clear_mat();
      for (int i = 0; i < MAX_N; i++)
        for (int j = 0; j < MAX_N; j++)
          mat[i][j] = (t % 2 == 0) ? int'($urandom_range(0, 4)) - 2
                                   : int'($urandom_range(0, 255)) - 128;
      run($sformatf("rand%0d", t), n, (n == 1) ? 2 : -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
